// File: rtl/al_fifo_rd_stream.sv
// rtl/al_fifo_rd_stream.sv - FWFT valid/ready stream adapter on the read port of AL_LOGIC_FIFO
// Issues FIFO reads ahead of demand and lands the fixed-latency read data in a Q-entry skid queue.
module al_fifo_rd_stream #(
  parameter int    DATA_WIDTH = 9,
  parameter string REGMODE_R  = "NOREG",
  localparam int   L  = (REGMODE_R == "NOREG") ? 1 : ((REGMODE_R == "OUTREG") ? 2 : 0),
  localparam int   Q  = L + 1,
  localparam int   LW = $clog2(Q + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_do,
  output logic                  fifo_re,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LW-1:0]         m_level
);

  localparam int PW = (Q > 1) ? $clog2(Q) : 1;
  localparam int CW = LW + 1;

  if (L == 0) begin : g_bad_regmode
    $error("al_fifo_rd_stream: REGMODE_R must be \"NOREG\" or \"OUTREG\"");
  end

  logic [L-1:0]          pipe;
  logic [DATA_WIDTH-1:0] mem [Q];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic [LW-1:0]         inflight;
  logic [CW-1:0]         occ;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(Q - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push = pipe[L-1];
  assign pop  = m_valid & m_ready;

  // A read is only issued if a queue slot is guaranteed when its data lands.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) begin
      inflight = inflight + LW'(pipe[i]);
    end
    occ     = CW'(count) + CW'(inflight) - CW'(pop);
    fifo_re = !rst && !fifo_empty && (occ < CW'(Q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe   <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      assert (!(push && count == LW'(Q)));
      pipe <= L'({pipe, fifo_re});
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_do;
  end

  assign m_data  = mem[rd_ptr];
  assign m_valid = (count != '0);
  assign m_level = count;

endmodule

// File: tb/tb_al_fifo_rd_stream.sv
// tb/tb_al_fifo_rd_stream.sv - bench for al_fifo_rd_stream in NOREG and OUTREG modes side by side
// Each instance gets its own FIFO model; a word-order scoreboard checks every stream beat.
module tb_al_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty  [2];
  logic [8:0] fdo    [2];
  logic       re     [2];
  logic [8:0] mdata  [2];
  logic       mvalid [2];
  logic       mready [2];
  logic [1:0] mlevel [2];

  always #5 clk = ~clk;

  al_fifo_rd_stream #(.DATA_WIDTH(9), .REGMODE_R("NOREG")) u_noreg (
    .clk(clk), .rst(rst), .fifo_empty(empty[0]), .fifo_do(fdo[0]), .fifo_re(re[0]),
    .m_data(mdata[0]), .m_valid(mvalid[0]), .m_ready(mready[0]), .m_level(mlevel[0]));

  al_fifo_rd_stream #(.DATA_WIDTH(9), .REGMODE_R("OUTREG")) u_outreg (
    .clk(clk), .rst(rst), .fifo_empty(empty[1]), .fifo_do(fdo[1]), .fifo_re(re[1]),
    .m_data(mdata[1]), .m_valid(mvalid[1]), .m_ready(mready[1]), .m_level(mlevel[1]));

  // FIFO model: read in cycle t empties from t+1, data appears in cycle t+1 (NOREG) or t+2 (OUTREG).
  logic [8:0] fmem [2][2048];
  int         wr_idx [2] = '{0, 0};
  int         rd_idx [2] = '{0, 0};
  logic       s1v;
  logic [8:0] s1;

  assign empty[0] = (wr_idx[0] == rd_idx[0]);
  assign empty[1] = (wr_idx[1] == rd_idx[1]);

  always @(posedge clk) begin
    if (rst) begin
      rd_idx[0] <= wr_idx[0];
      rd_idx[1] <= wr_idx[1];
      s1v       <= 1'b0;
      fdo[0]    <= 9'($urandom);
      fdo[1]    <= 9'($urandom);
    end else begin
      if (re[0]) rd_idx[0] <= rd_idx[0] + 1;
      if (re[1]) rd_idx[1] <= rd_idx[1] + 1;
      fdo[0] <= re[0] ? fmem[0][rd_idx[0]] : 9'($urandom);
      s1v    <= re[1];
      s1     <= fmem[1][rd_idx[1]];
      fdo[1] <= s1v ? s1 : 9'($urandom);
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         cyc_n  = 0;
  int         beats [2];
  int         first_beat [2];
  int         last_beat [2];
  int         reads [2];
  logic       held [2] = '{1'b0, 1'b0};
  logic [8:0] hdata [2];
  logic [8:0] exp0 [$];
  logic [8:0] exp1 [$];

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, expv);
    end
  endtask

  function automatic int qlen(input int k);
    return (k == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic push_both(input logic [8:0] w);
    for (int k = 0; k < 2; k++) begin
      fmem[k][wr_idx[k]] = w;
      wr_idx[k] = wr_idx[k] + 1;
    end
    exp0.push_back(w);
    exp1.push_back(w);
  endtask

  task automatic clr_stats();
    for (int k = 0; k < 2; k++) begin
      beats[k] = 0; first_beat[k] = -1; last_beat[k] = -1; reads[k] = 0;
    end
  endtask

  task automatic mon(input int k);
    logic [8:0] front;
    check("level_le_q", k, 32'(int'(mlevel[k]) <= k + 2), 32'd1);
    if (rst) begin
      check("re_in_reset", k, 32'(re[k]), 32'd0);
      held[k] = 1'b0;
    end else begin
      if (re[k]) begin
        reads[k]++;
        check("re_while_empty", k, 32'(empty[k]), 32'd0);
      end
      if (held[k]) begin
        check("valid_hold", k, 32'(mvalid[k]), 32'd1);
        check("data_hold", k, 32'(mdata[k]), 32'(hdata[k]));
      end
      if (mvalid[k] && mready[k]) begin
        beats[k]++;
        if (first_beat[k] < 0) first_beat[k] = cyc_n;
        last_beat[k] = cyc_n;
        check("sb_nonempty", k, 32'(qlen(k) != 0), 32'd1);
        if (qlen(k) != 0) begin
          if (k == 0) front = exp0.pop_front();
          else        front = exp1.pop_front();
          check("beat_data", k, 32'(mdata[k]), 32'(front));
        end
      end
      held[k]  = mvalid[k] && !mready[k];
      hdata[k] = mdata[k];
    end
  endtask

  // Inputs are set at the falling edge; the cycle is checked 1ns later, well before the rising edge.
  task automatic cyc();
    #1;
    mon(0);
    mon(1);
    if (rst) begin
      exp0.delete();
      exp1.delete();
    end
    cyc_n++;
    @(negedge clk);
  endtask

  initial begin
    int start;
    int pushed;
    bit done;

    rst = 1'b1;
    mready[0] = 1'b0;
    mready[1] = 1'b0;
    clr_stats();
    @(negedge clk);
    push_both(9'h1FF);
    cyc();
    cyc();
    for (int k = 0; k < 2; k++) begin
      check("reset_valid", k, 32'(mvalid[k]), 32'd0);
      check("reset_level", k, 32'(mlevel[k]), 32'd0);
    end
    rst = 1'b0;
    cyc();
    cyc();

    // Back-to-back burst of 16 words with the consumer always ready
    mready[0] = 1'b1;
    mready[1] = 1'b1;
    clr_stats();
    start = cyc_n;
    for (int i = 1; i <= 16; i++) push_both(9'(i));
    repeat (40) cyc();
    for (int k = 0; k < 2; k++) begin
      check("first_latency", k, 32'(first_beat[k] - start), 32'(k + 2));
      check("burst_span", k, 32'(last_beat[k] - first_beat[k]), 32'd15);
      check("burst_beats", k, 32'(beats[k]), 32'd16);
      check("burst_idle", k, 32'(mvalid[k]), 32'd0);
      check("burst_drained", k, 32'(qlen(k)), 32'd0);
    end

    // Stall with 8 words queued, then release
    mready[0] = 1'b0;
    mready[1] = 1'b0;
    clr_stats();
    for (int i = 0; i < 8; i++) push_both(9'h100 + 9'(i));
    repeat (10) cyc();
    for (int k = 0; k < 2; k++) begin
      check("stall_reads", k, 32'(reads[k]), 32'(k + 2));
      check("stall_level", k, 32'(mlevel[k]), 32'(k + 2));
      check("stall_data", k, 32'(mdata[k]), 32'h100);
      check("stall_valid", k, 32'(mvalid[k]), 32'd1);
    end
    mready[0] = 1'b1;
    mready[1] = 1'b1;
    clr_stats();
    repeat (30) cyc();
    for (int k = 0; k < 2; k++) begin
      check("release_beats", k, 32'(beats[k]), 32'd8);
      check("release_span", k, 32'(last_beat[k] - first_beat[k]), 32'd7);
      check("release_drained", k, 32'(qlen(k)), 32'd0);
    end

    // Single word
    clr_stats();
    push_both(9'h0A5);
    repeat (10) cyc();
    for (int k = 0; k < 2; k++) begin
      check("single_reads", k, 32'(reads[k]), 32'd1);
      check("single_beats", k, 32'(beats[k]), 32'd1);
      check("single_idle", k, 32'(mvalid[k]), 32'd0);
    end

    // Random producer and 50% random consumer, 1000 words
    clr_stats();
    pushed = 0;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      mready[0] = 1'($urandom_range(0, 1));
      mready[1] = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        push_both(9'($urandom));
        pushed++;
      end
      cyc();
      done = (pushed == 1000) && (qlen(0) == 0) && (qlen(1) == 0);
    end
    check("random_done", 0, 32'(done), 32'd1);
    for (int k = 0; k < 2; k++) begin
      check("random_beats", k, 32'(beats[k]), 32'd1000);
    end

    // Reset while reads are in flight, then refill
    mready[0] = 1'b1;
    mready[1] = 1'b1;
    repeat (3) cyc();
    clr_stats();
    for (int i = 0; i < 8; i++) push_both(9'h180 + 9'(i));
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("midrst_valid", k, 32'(mvalid[k]), 32'd0);
      check("midrst_level", k, 32'(mlevel[k]), 32'd0);
    end
    cyc();
    clr_stats();
    for (int i = 0; i < 4; i++) push_both(9'h1C0 + 9'(i));
    repeat (20) cyc();
    for (int k = 0; k < 2; k++) begin
      check("refill_beats", k, 32'(beats[k]), 32'd4);
      check("refill_drained", k, 32'(qlen(k)), 32'd0);
      check("refill_idle", k, 32'(mvalid[k]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/al_fifo_rd_stream.md
# al_fifo_rd_stream

Single-clock read-side adapter for the AL_LOGIC_FIFO soft/hard FIFO. It drives the FIFO read strobe from the empty flag and absorbs the FIFO's fixed read latency (NOREG or OUTREG) in a small skid queue. The consumer sees a first-word-fall-through valid/ready stream at one word per clock. It sits directly downstream of the FIFO read port, with the FIFO read clock tied to `clk`.

## Interface
Parameters:
- `DATA_WIDTH`, 9: FIFO read data width (`DATA_WIDTH_R` of the FIFO).
- `REGMODE_R`, "NOREG": must match the FIFO setting. "NOREG" gives read latency L=1; "OUTREG" gives L=2. Any other value is a configuration error and must fail elaboration.
- Derived `Q` = L+1: skid queue depth.

Ports:
- `clk`  in  1  clock. The FIFO read clock is tied to it.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty_flag`.
- `fifo_do`  in  DATA_WIDTH  FIFO `do`.
- `fifo_re`  out  1  FIFO `re`. The integrator ties the FIFO `ore` high.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_level`  out  clog2(Q+1)  words held in the queue.

## Operation
Signals:
- `pop` = `m_valid & m_ready`.
- `inflight` = number of reads issued in the last L cycles, tracked by an L-bit valid shift pipe.
- `count` = current queue occupancy.

Read issue:
- `fifo_re` = `!rst & !fifo_empty & (count + inflight - pop < Q)`.
- This is combinational, at most one read per cycle.
- `fifo_re` is never asserted while `fifo_empty`=1.

FIFO contract:
- A read issued in cycle t is reflected in `fifo_empty` from cycle t+1.
- Read data is valid on `fifo_do` during cycle t+L.

Return path:
- Pipe bit 0 is set by `fifo_re`. The pipe shifts each cycle.
- When pipe bit L-1 is set, `fifo_do` is written into the queue at `wr_ptr` at the end of that cycle.

Queue:
- Circular register array of Q entries, with `wr_ptr`, `rd_ptr` and `count`.
- Push and pop in the same cycle leave `count` unchanged; both pointers advance.
- Pointers wrap from Q-1 to 0.

Outputs:
- `m_data` = `queue[rd_ptr]`, driven from registers with no combinational path from `fifo_do`.
- `m_valid` = (`count` != 0).
- `m_level` = `count`.

Invariant:
- `count + inflight <= Q` at all times, so the queue never overflows.
- A push into a full queue is a design error; an assertion must flag it.

Stream rules:
- Once asserted, `m_valid` and `m_data` hold until `pop`.
- `m_ready` may toggle freely.

## Timing
- Reset values: `count`=0, `wr_ptr`=0, `rd_ptr`=0, pipe=0, `m_valid`=0, `m_level`=0, `fifo_re`=0 (gated by `rst`). `m_data` is don't-care while `m_valid`=0; queue contents are not reset.
- Reset mid-operation discards queued and in-flight words. The FIFO must be reset by the same `rst`.
- First-word latency: `fifo_empty` falls in cycle 0, `fifo_re` in cycle 0, `m_valid` rises in cycle L+1.
- Throughput: with `m_ready` held high and the FIFO non-empty, one word per cycle in steady state.
- Backpressure: with `m_ready`=0, reads stop once `count + inflight` = Q. In-flight words still land. No word is lost or duplicated.
- Restart: when `m_ready` rises with `count`=Q, the `pop` in that cycle re-enables `fifo_re` in the same cycle.
- Empty: while `fifo_empty`=1 no reads are issued. Queued and in-flight words still drain normally.
- Ordering: output order is identical to FIFO order.

## Test plan
- **NOREG stream:** write 0x001..0x010 into the FIFO, `m_ready`=1 → `m_valid` rises 2 cycles after `fifo_empty` falls. 16 consecutive beats 0x001..0x010, then `m_valid`=0.
- **OUTREG stream:** same stimulus with L=2 → first beat 3 cycles after `fifo_empty` falls, then 16 back-to-back beats.
- **Stall:** `m_ready`=0 for 10 cycles with the FIFO holding 8 words → `fifo_re` stops after Q reads; `m_level`=Q; `m_data` frozen at word 1. Release → remaining words in order, no gaps after the first.
- **Random `m_ready`:** 50% random `m_ready`, 1000 words → scoreboard exact match; `count` never exceeds Q; no read while `fifo_empty`=1.
- **Single word:** one FIFO word, `m_ready`=1 → exactly one `fifo_re` pulse, one beat, then idle.
- **Reset mid-burst:** assert `rst` for 1 cycle while L words are in flight → next cycle `m_valid`=0, `m_level`=0; stream resumes correctly after a refill.
